alu_input_seq: RTL



---
 rtl/alu_input_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_input_seq.sv
// Operand/opcode entry sequencer for the board calculator: steps through N_OPS operand
// entries and one opcode entry, then latches the external ALU result until acknowledged.
module alu_input_seq #(
    parameter int N_OPS = 2,
    parameter int W     = 16,
    parameter int OPW   = 2,
    parameter int CHAIN = 0
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 exe,
    input  logic                 back,
    input  logic                 clr,
    input  logic [W-1:0]         din,
    input  logic [W-1:0]         res_in,
    output logic [N_OPS*W-1:0]   operands,
    output logic [OPW-1:0]       opcode,
    output logic [N_OPS:0]       stage_sel,
    output logic                 disp_rst,
    output logic [3:0]           c_state,
    output logic [W-1:0]         result,
    output logic                 result_valid
);

    localparam int              IW       = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(N_OPS - 1);
    localparam logic [31:0]     N_OPS_U  = 32'(N_OPS);
    localparam logic [N_OPS:0]  SEL_ONE  = (N_OPS + 1)'(1);

    typedef enum logic [2:0] {
        S_OPND   = 3'd0,
        S_OPER   = 3'd1,
        S_SETTLE = 3'd2,
        S_RESULT = 3'd3
    } state_t;

    state_t          state_reg, state_next;
    state_t          tgt_reg, tgt_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [IW-1:0]   tgt_idx_reg, tgt_idx_next;

    logic            opnd_we;
    logic [IW-1:0]   opnd_wsel;
    logic [W-1:0]    opnd_wdata;
    logic            opcode_we;
    logic            result_we;
    logic            valid_next;

    logic [OPW-1:0]  opcode_reg;
    logic [W-1:0]    result_reg;
    logic            result_valid_reg;

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_reg   <= S_OPND;
            idx_reg     <= '0;
            tgt_reg     <= S_OPND;
            tgt_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            tgt_reg     <= tgt_next;
            tgt_idx_reg <= tgt_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        tgt_next     = tgt_reg;
        tgt_idx_next = tgt_idx_reg;
        opnd_we      = 1'b0;
        opnd_wsel    = idx_reg;
        opnd_wdata   = din;
        opcode_we    = 1'b0;
        result_we    = 1'b0;
        valid_next   = result_valid_reg;
        stage_sel    = '0;
        disp_rst     = 1'b0;
        c_state      = 4'hE;

        case (state_reg)
            S_OPND: begin
                // An out-of-range operand index is treated like any other illegal encoding
                if (32'(idx_reg) >= N_OPS_U) begin
                    state_next = S_OPND;
                    idx_next   = '0;
                end else begin
                    stage_sel = SEL_ONE << idx_reg;
                    c_state   = 4'(idx_reg);
                    if (exe) begin
                        opnd_we    = 1'b1;
                        state_next = S_SETTLE;
                        if (idx_reg == LAST_IDX) begin
                            tgt_next = S_OPER;
                        end else begin
                            tgt_next     = S_OPND;
                            tgt_idx_next = idx_reg + 1'b1;
                        end
                    end else if (back && idx_reg != '0) begin
                        idx_next = idx_reg - 1'b1;
                    end
                end
            end
            S_OPER: begin
                stage_sel[N_OPS] = 1'b1;
                c_state          = 4'(N_OPS);
                if (exe) begin
                    opcode_we  = 1'b1;
                    state_next = S_SETTLE;
                    tgt_next   = S_RESULT;
                end else if (back) begin
                    state_next = S_OPND;
                    idx_next   = LAST_IDX;
                end
            end
            S_SETTLE: begin
                disp_rst   = 1'b1;
                c_state    = 4'hF;
                state_next = tgt_reg;
                idx_next   = tgt_idx_reg;
                // Operands/opcode have been stable for a full cycle, so res_in is safe to latch
                if (tgt_reg == S_RESULT) begin
                    result_we  = 1'b1;
                    valid_next = 1'b1;
                end
            end
            S_RESULT: begin
                c_state = 4'(N_OPS + 1);
                if (exe) begin
                    valid_next = 1'b0;
                    state_next = S_SETTLE;
                    if (CHAIN != 0) begin
                        opnd_we    = 1'b1;
                        opnd_wsel  = '0;
                        opnd_wdata = result_reg;
                        if (N_OPS == 1) begin
                            tgt_next = S_OPER;
                        end else begin
                            tgt_next     = S_OPND;
                            tgt_idx_next = IW'(1);
                        end
                    end else begin
                        tgt_next     = S_OPND;
                        tgt_idx_next = '0;
                    end
                end else if (back) begin
                    state_next = S_OPER;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = S_OPND;
                idx_next   = '0;
            end
        endcase

        if (clr) begin
            state_next = S_OPND;
            idx_next   = '0;
            valid_next = 1'b0;
            opnd_we    = 1'b0;
            opcode_we  = 1'b0;
            result_we  = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N_OPS; gi++) begin : g_opnd
            logic [W-1:0] opnd_reg;
            always_ff @(posedge CLK100MHZ) begin
                if (rst) begin
                    opnd_reg <= '0;
                end else if (opnd_we && opnd_wsel == IW'(gi)) begin
                    opnd_reg <= opnd_wdata;
                end
            end
            assign operands[gi*W +: W] = opnd_reg;
        end
    endgenerate

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            opcode_reg       <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            if (opcode_we) begin
                opcode_reg <= din[OPW-1:0];
            end
            if (result_we) begin
                result_reg <= res_in;
            end
            result_valid_reg <= valid_next;
        end
    end

    assign opcode       = opcode_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;

endmodule
